// File: rtl/regfile_requester_if.sv
// Client-side handshake bundle for regfile_requester: command channel,
// init request/status, and read-response channel.
interface regfile_requester_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic [AW-1:0] cmd_addr0;
  logic [AW-1:0] cmd_addr1;
  logic [DW-1:0] cmd_data0;
  logic [DW-1:0] cmd_data1;
  logic          init_start;
  logic          init_busy;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data0;
  logic [DW-1:0] rsp_data1;

  // Client side: issues commands and consumes responses.
  modport master (
    output cmd_valid, cmd_op, cmd_addr0, cmd_addr1, cmd_data0, cmd_data1,
    output init_start, rsp_ready,
    input  cmd_ready, init_busy, rsp_valid, rsp_data0, rsp_data1
  );

  // Sequencer side: accepts commands and produces responses.
  modport slave (
    input  cmd_valid, cmd_op, cmd_addr0, cmd_addr1, cmd_data0, cmd_data1,
    input  init_start, rsp_ready,
    output cmd_ready, init_busy, rsp_valid, rsp_data0, rsp_data1
  );
endinterface

// File: rtl/regfile_requester.sv
// Initiator-side sequencer for a 2^AW-entry register file with two write
// ports (a/b) and two synchronous read ports (c/d). Executes write-pair and
// read-pair commands and a bulk-initialise walk. All register-file outputs
// are registered and loaded on the edge that enters the state using them,
// so they are valid for the whole WR/RD/INIT cycle.
module regfile_requester #(
  parameter int            AW       = 5,
  parameter int            DW       = 32,
  parameter logic [DW-1:0] INIT_VAL = {DW{1'b0}}
) (
  input  logic          clk,
  input  logic          reset,
  regfile_requester_if.slave bus,
  output logic [AW-1:0] rf_add_a,
  output logic [AW-1:0] rf_add_b,
  output logic [AW-1:0] rf_add_c,
  output logic [AW-1:0] rf_add_d,
  output logic [DW-1:0] rf_din_a,
  output logic [DW-1:0] rf_din_b,
  output logic [DW-1:0] rf_din_c,
  output logic [DW-1:0] rf_din_d,
  output logic          rf_we,
  input  logic [DW-1:0] rf_dout_a,
  input  logic [DW-1:0] rf_dout_b
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    CAP  = 3'd3,
    RESP = 3'd4,
    INIT = 3'd5
  } state_t;

  // Last even address of the init walk; the pair (CNT_LAST, CNT_LAST+1) ends it.
  localparam logic [AW-1:0] CNT_LAST = AW'((2 ** AW) - 2);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] add_a_q, add_a_d, add_b_q, add_b_d;
  logic [AW-1:0] add_c_q, add_c_d, add_d_q, add_d_d;
  logic [DW-1:0] din_a_q, din_a_d, din_b_q, din_b_d;
  logic          we_q, we_d;
  logic          busy_q, busy_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data0_q, rsp_data0_d, rsp_data1_q, rsp_data1_d;
  logic          same_addr_s;

  assign same_addr_s = (bus.cmd_addr0 == bus.cmd_addr1);

  // Next-state and next-output computation for the sequencer FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_c_d     = add_c_q;
    add_d_d     = add_d_q;
    din_a_d     = din_a_q;
    din_b_d     = din_b_q;
    we_d        = 1'b0;
    busy_d      = busy_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data0_d = rsp_data0_q;
    rsp_data1_d = rsp_data1_q;
    case (state_q)
      IDLE: begin
        if (bus.init_start) begin
          // Init wins over a simultaneous command; the command stays pending.
          state_d = INIT;
          cnt_d   = {AW{1'b0}};
          add_a_d = {AW{1'b0}};
          add_b_d = AW'(1);
          din_a_d = INIT_VAL;
          din_b_d = INIT_VAL;
          we_d    = 1'b1;
          busy_d  = 1'b1;
        end else if (bus.cmd_valid) begin
          if (bus.cmd_op) begin
            // Same-address pair: drive both ports with addr1/data1 so the
            // result does not depend on the file's port priority.
            state_d = WR;
            add_a_d = same_addr_s ? bus.cmd_addr1 : bus.cmd_addr0;
            din_a_d = same_addr_s ? bus.cmd_data1 : bus.cmd_data0;
            add_b_d = bus.cmd_addr1;
            din_b_d = bus.cmd_data1;
            we_d    = 1'b1;
          end else begin
            state_d = RD;
            add_c_d = bus.cmd_addr0;
            add_d_d = bus.cmd_addr1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WR: begin
        state_d = IDLE;
      end
      RD: begin
        // Read addresses are on c/d this cycle; data arrives next cycle.
        state_d = CAP;
      end
      CAP: begin
        rsp_data0_d = rf_dout_a;
        rsp_data1_d = rf_dout_b;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      INIT: begin
        if (cnt_q == CNT_LAST) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + AW'(2);
          add_a_d = cnt_q + AW'(2);
          add_b_d = cnt_q + AW'(3);
          we_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered-output flops; reset abandons any operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= {AW{1'b0}};
      add_a_q     <= {AW{1'b0}};
      add_b_q     <= {AW{1'b0}};
      add_c_q     <= {AW{1'b0}};
      add_d_q     <= {AW{1'b0}};
      din_a_q     <= {DW{1'b0}};
      din_b_q     <= {DW{1'b0}};
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data0_q <= {DW{1'b0}};
      rsp_data1_q <= {DW{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_c_q     <= add_c_d;
      add_d_q     <= add_d_d;
      din_a_q     <= din_a_d;
      din_b_q     <= din_b_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data0_q <= rsp_data0_d;
      rsp_data1_q <= rsp_data1_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE) && !bus.init_start;
  assign bus.init_busy = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data0 = rsp_data0_q;
  assign bus.rsp_data1 = rsp_data1_q;

  assign rf_add_a = add_a_q;
  assign rf_add_b = add_b_q;
  assign rf_add_c = add_c_q;
  assign rf_add_d = add_d_q;
  assign rf_din_a = din_a_q;
  assign rf_din_b = din_b_q;
  assign rf_din_c = {DW{1'b0}};
  assign rf_din_d = {DW{1'b0}};
  assign rf_we    = we_q;

endmodule

// File: tb/tb_regfile_requester.sv
// Directed + randomized bench for regfile_requester. A behavioural register
// file sits on the rf_* ports; a separate array tracks what the file should
// hold, updated per accepted command / init walk.
module tb_regfile_requester;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NREG = 32;
  localparam logic [31:0] IV = 32'h1234_5678;

  logic clk = 1'b0;
  logic reset;
  logic [AW-1:0] rf_add_a, rf_add_b, rf_add_c, rf_add_d;
  logic [DW-1:0] rf_din_a, rf_din_b, rf_din_c, rf_din_d;
  logic          rf_we;
  logic [DW-1:0] rf_dout_a, rf_dout_b;

  regfile_requester_if #(.AW(AW), .DW(DW)) bus ();

  regfile_requester #(.AW(AW), .DW(DW), .INIT_VAL(IV)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .rf_add_a(rf_add_a), .rf_add_b(rf_add_b), .rf_add_c(rf_add_c), .rf_add_d(rf_add_d),
    .rf_din_a(rf_din_a), .rf_din_b(rf_din_b), .rf_din_c(rf_din_c), .rf_din_d(rf_din_d),
    .rf_we(rf_we), .rf_dout_a(rf_dout_a), .rf_dout_b(rf_dout_b)
  );

  always #5 clk = ~clk;

  // Behavioural register file: port b written last, synchronous read.
  logic [DW-1:0] mem [NREG];
  always @(posedge clk) begin
    if (rf_we) begin
      mem[rf_add_a] <= rf_din_a;
      mem[rf_add_b] <= rf_din_b;
    end
    rf_dout_a <= mem[rf_add_c];
    rf_dout_b <= mem[rf_add_d];
  end

  logic [31:0] ref_mem [NREG];
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rf_add"}, {rf_add_a, rf_add_b, rf_add_c, rf_add_d}, 64'd0);
    chk({tag, "_rf_din"}, {rf_din_a, rf_din_b}, 64'd0);
    chk({tag, "_rf_we"}, rf_we, 64'd0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 64'd0);
    chk({tag, "_rsp_data"}, {bus.rsp_data0, bus.rsp_data1}, 64'd0);
    chk({tag, "_init_busy"}, bus.init_busy, 64'd0);
  endtask

  // Present a command and hold it until accepted (bounded). Returns the
  // number of cycles spent waiting for cmd_ready.
  task automatic accept(input logic op, input logic [4:0] a0, input logic [31:0] d0,
                        input logic [4:0] a1, input logic [31:0] d1, output int waits);
    bit done = 0;
    waits = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_addr0 = a0; bus.cmd_data0 = d0;
    bus.cmd_addr1 = a1; bus.cmd_data1 = d1;
    while (!done && waits < 100) begin
      if (bus.cmd_ready) done = 1;
      else waits++;
      tick();
    end
    bus.cmd_valid = 1'b0;
    if (!done) chk("accept_timeout", 64'd0, 64'd1);
    else if (op) begin
      ref_mem[a0] = d0;
      ref_mem[a1] = d1;
    end
  endtask

  task automatic do_write(input logic [4:0] a0, input logic [31:0] d0,
                          input logic [4:0] a1, input logic [31:0] d1);
    int w;
    accept(1'b1, a0, d0, a1, d1, w);
    chk("wr_we", rf_we, 64'd1);
    chk("wr_add_a", rf_add_a, a0);
    chk("wr_add_b", rf_add_b, a1);
    chk("wr_din_b", rf_din_b, d1);
    chk("wr_din_a", rf_din_a, (a0 == a1) ? d1 : d0);
    tick();
    chk("wr_we_drop", rf_we, 64'd0);
  endtask

  // Read with `stall` cycles of rsp_ready low once the response appears.
  task automatic do_read(input logic [4:0] a0, input logic [4:0] a1, input int stall);
    int w;
    logic [31:0] e0, e1;
    e0 = ref_mem[a0];
    e1 = ref_mem[a1];
    bus.rsp_ready = 1'b0;
    accept(1'b0, a0, 32'd0, a1, 32'd0, w);
    // Accept edge is edge 1; the response appears after edge 3.
    chk("rd_valid_e1", bus.rsp_valid, 64'd0);
    tick();
    chk("rd_valid_e2", bus.rsp_valid, 64'd0);
    tick();
    chk("rd_valid_e3", bus.rsp_valid, 64'd1);
    chk("rd_data0", bus.rsp_data0, e0);
    chk("rd_data1", bus.rsp_data1, e1);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("rd_hold_valid", bus.rsp_valid, 64'd1);
      chk("rd_hold_data", {bus.rsp_data0, bus.rsp_data1}, {e0, e1});
      chk("rd_hold_cmd_ready", bus.cmd_ready, 64'd0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("rd_valid_drop", bus.rsp_valid, 64'd0);
    chk("rd_cmd_ready_back", bus.cmd_ready, 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    for (int i = 0; i < NREG; i++) begin
      mem[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 1'b0;
    bus.cmd_addr0 = '0; bus.cmd_addr1 = '0;
    bus.cmd_data0 = '0; bus.cmd_data1 = '0;
    bus.init_start = 1'b0; bus.rsp_ready = 1'b0;
    tick(); tick();
    chk_all_zero("reset");
    chk("reset_din_cd", {rf_din_c, rf_din_d}, 64'd0);
    reset = 1'b0;
    chk("post_reset_cmd_ready", bus.cmd_ready, 64'd1);

    // Write then read back.
    do_write(5'd1, 32'hAAAA_AAAA, 5'd17, 32'hFFFF_FFFF);
    do_read(5'd1, 5'd17, 0);

    // Response backpressure.
    do_read(5'd1, 5'd17, 5);

    // Init walk: busy for exactly 16 cycles covering pairs (0,1)..(30,31).
    bus.init_start = 1'b1;
    #1;
    chk("init_cmd_ready_low", bus.cmd_ready, 64'd0);
    tick();
    bus.init_start = 1'b0;
    for (int k = 0; k < NREG / 2; k++) begin
      chk("init_busy", bus.init_busy, 64'd1);
      chk("init_we", rf_we, 64'd1);
      chk("init_pair", {rf_add_a, rf_add_b}, {5'(2 * k), 5'(2 * k + 1)});
      chk("init_din", {rf_din_a, rf_din_b}, {IV, IV});
      chk("init_cmd_ready", bus.cmd_ready, 64'd0);
      tick();
    end
    chk("init_busy_end", bus.init_busy, 64'd0);
    chk("init_we_end", rf_we, 64'd0);
    for (int i = 0; i < NREG; i++) ref_mem[i] = IV;
    do_read(5'd0, 5'd31, 0);

    // Init and command in the same IDLE cycle: init first, command pending.
    bus.cmd_valid = 1'b1; bus.cmd_op = 1'b1;
    bus.init_start = 1'b1;
    #1;
    chk("prio_cmd_ready", bus.cmd_ready, 64'd0);
    tick();
    bus.init_start = 1'b0;
    chk("prio_init_busy", bus.init_busy, 64'd1);
    for (int i = 0; i < NREG; i++) ref_mem[i] = IV;
    accept(1'b1, 5'd3, 32'hCAFE_0003, 5'd20, 32'hBEEF_0020, w);
    chk("prio_wait_cycles", w, 64'd16);
    tick();
    do_read(5'd3, 5'd20, 1);

    // Same-address write: data1 wins.
    do_write(5'd5, 32'h1111_1111, 5'd5, 32'h2222_2222);
    do_read(5'd5, 5'd5, 0);

    // Randomized command mix against the reference array.
    for (int n = 0; n < 30; n++) begin
      logic [4:0] ra0, ra1;
      ra0 = 5'($urandom_range(0, NREG - 1));
      ra1 = 5'($urandom_range(0, NREG - 1));
      if ($urandom_range(0, 1) == 1)
        do_write(ra0, $urandom, ra1, $urandom);
      else
        do_read(ra0, ra1, int'($urandom_range(0, 3)));
    end

    // Reset in the middle of the init walk (cnt = 8).
    bus.init_start = 1'b1;
    tick();
    bus.init_start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("mid_init_cnt8", rf_add_a, 64'd8);
    for (int i = 0; i < 8; i++) ref_mem[i] = IV;
    reset = 1'b1;
    #1;
    chk_all_zero("reset_in_init");
    tick();
    reset = 1'b0;
    chk("init_rst_cmd_ready", bus.cmd_ready, 64'd1);
    tick();
    chk("init_rst_no_busy", bus.init_busy, 64'd0);
    do_read(5'd7, 5'd8, 0);

    // Reset while a response is being held.
    bus.rsp_ready = 1'b0;
    accept(1'b0, 5'd0, 32'd0, 5'd9, 32'd0, w);
    tick(); tick();
    chk("resp_before_reset", bus.rsp_valid, 64'd1);
    reset = 1'b1;
    #1;
    chk_all_zero("reset_in_resp");
    tick();
    reset = 1'b0;
    chk("resp_rst_cmd_ready", bus.cmd_ready, 64'd1);
    tick();
    chk("resp_rst_no_stale", bus.rsp_valid, 64'd0);
    do_read(5'd0, 5'd9, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
